// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the req/ack instruction-memory
// port (one outstanding request) and holds the IF/ID pipeline register.
//
// state | meaning
// ------+---------------------------------------------------------------
// RUN   | request at pc outstanding (or issuing); responses are used
// DROP  | stale pre-redirect request at drop_addr still outstanding; its
//       | response is discarded, pc already points at the new path
// HOLD  | no request; an instruction fetched during a stall is parked in
//       | hold_instr/hold_pc until IF/ID can accept it
module fetch_stage #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR    = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fetch_in_pcWrite,
    input  logic        fetch_in_IF_ID_write_en,
    input  logic        fetch_in_redirect,
    input  logic [31:0] fetch_in_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] fetch_out_pc,
    output logic [31:0] fetch_out_instr,
    output logic [31:0] fetch_out_pc_plus_four,
    output logic        fetch_out_valid
);

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_DROP = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] drop_addr_q, drop_addr_d;
    logic [31:0] hold_instr_q, hold_instr_d;
    logic [31:0] hold_pc_q, hold_pc_d;
    logic [31:0] ifid_pc_q, ifid_pc_d;
    logic [31:0] ifid_instr_q, ifid_instr_d;
    logic [31:0] ifid_ppf_q, ifid_ppf_d;
    logic        ifid_valid_q, ifid_valid_d;

    logic        stall;
    logic [31:0] pc_plus_four;
    logic [31:0] target_aligned;

    assign stall          = !fetch_in_pcWrite || !fetch_in_IF_ID_write_en;
    assign pc_plus_four   = pc_q + 32'd4;
    assign target_aligned = {fetch_in_target[31:2], 2'b00};

    // Memory port: request is a pure function of state so it never drops
    // before its ack; reset forces it low because imem resets with us.
    always_comb begin
        imem_req  = !reset && (state_q != ST_HOLD);
        imem_addr = (state_q == ST_DROP) ? drop_addr_q : pc_q;
    end

    // Next-state: redirect beats stall beats normal fetch.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        drop_addr_d  = drop_addr_q;
        hold_instr_d = hold_instr_q;
        hold_pc_d    = hold_pc_q;
        ifid_pc_d    = ifid_pc_q;
        ifid_instr_d = ifid_instr_q;
        ifid_ppf_d   = ifid_ppf_q;
        ifid_valid_d = ifid_valid_q;

        if (fetch_in_redirect) begin
            pc_d         = target_aligned;
            ifid_pc_d    = 32'd0;
            ifid_instr_d = NOP_INSTR;
            ifid_ppf_d   = 32'd0;
            ifid_valid_d = 1'b0;
            hold_instr_d = NOP_INSTR;
            hold_pc_d    = 32'd0;
            unique case (state_q)
                ST_RUN: begin
                    // An unacked request cannot be aborted; let it finish in DROP.
                    if (!imem_ack) begin
                        drop_addr_d = pc_q;
                        state_d     = ST_DROP;
                    end
                end
                ST_DROP: begin
                    if (imem_ack) state_d = ST_RUN;
                end
                default: state_d = ST_RUN;
            endcase
        end else begin
            unique case (state_q)
                ST_RUN: begin
                    if (imem_ack) begin
                        pc_d = pc_plus_four;
                        if (stall) begin
                            hold_instr_d = imem_rdata;
                            hold_pc_d    = pc_q;
                            state_d      = ST_HOLD;
                        end else begin
                            ifid_pc_d    = pc_q;
                            ifid_instr_d = imem_rdata;
                            ifid_ppf_d   = pc_plus_four;
                            ifid_valid_d = 1'b1;
                        end
                    end else if (!stall) begin
                        ifid_pc_d    = 32'd0;
                        ifid_instr_d = NOP_INSTR;
                        ifid_ppf_d   = 32'd0;
                        ifid_valid_d = 1'b0;
                    end
                end
                ST_DROP: begin
                    if (imem_ack) state_d = ST_RUN;
                    if (!stall) begin
                        ifid_pc_d    = 32'd0;
                        ifid_instr_d = NOP_INSTR;
                        ifid_ppf_d   = 32'd0;
                        ifid_valid_d = 1'b0;
                    end
                end
                default: begin
                    if (!stall) begin
                        ifid_pc_d    = hold_pc_q;
                        ifid_instr_d = hold_instr_q;
                        ifid_ppf_d   = hold_pc_q + 32'd4;
                        ifid_valid_d = 1'b1;
                        state_d      = ST_RUN;
                    end
                end
            endcase
        end
    end

    // State and IF/ID register, synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_RUN;
            pc_q         <= {RESET_VECTOR[31:2], 2'b00};
            drop_addr_q  <= 32'd0;
            hold_instr_q <= NOP_INSTR;
            hold_pc_q    <= 32'd0;
            ifid_pc_q    <= 32'd0;
            ifid_instr_q <= NOP_INSTR;
            ifid_ppf_q   <= 32'd0;
            ifid_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            drop_addr_q  <= drop_addr_d;
            hold_instr_q <= hold_instr_d;
            hold_pc_q    <= hold_pc_d;
            ifid_pc_q    <= ifid_pc_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_ppf_q   <= ifid_ppf_d;
            ifid_valid_q <= ifid_valid_d;
        end
    end

    assign fetch_out_pc           = ifid_pc_q;
    assign fetch_out_instr        = ifid_instr_q;
    assign fetch_out_pc_plus_four = ifid_ppf_q;
    assign fetch_out_valid        = ifid_valid_q;

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the five-stage RV32I pipeline, directly upstream of decode.
- Owns the PC and drives a req/ack instruction-memory port (variable latency, one outstanding request).
- Contains the IF/ID pipeline register that feeds decode's pc, instr and pc_plus_four inputs.
- Obeys the hazard unit's pcWrite / IF_ID_write_en stall and the EX-stage redirect for taken branch, jal and jalr.

Parameters:
RESET_VECTOR, 32'h0000_0000, PC value loaded on reset.
NOP_INSTR, 32'h0000_0013, instruction (addi x0,x0,0) inserted as a bubble.

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
fetch_in_pcWrite  in  1  hazard unit PC write enable; 0 = stall
fetch_in_IF_ID_write_en  in  1  hazard unit IF/ID write enable; 0 = stall
fetch_in_redirect  in  1  EX-stage taken branch/jump; also flushes IF/ID
fetch_in_target  in  32  redirect target address
imem_req  out  1  instruction request, level
imem_addr  out  32  request address, word aligned
imem_ack  in  1  request completes at this edge; sampled only while imem_req=1
imem_rdata  in  32  instruction, valid when imem_ack=1
fetch_out_pc  out  32  IF/ID pc (to decode_in_pc)
fetch_out_instr  out  32  IF/ID instruction (to decode_in_instr)
fetch_out_pc_plus_four  out  32  IF/ID pc+4 (to decode_in_pc_plus_four)
fetch_out_valid  out  1  1 = real instruction, 0 = bubble

Behaviour:
- Define stall = !fetch_in_pcWrite | !fetch_in_IF_ID_write_en.
- Reset: state=RUN, pc=RESET_VECTOR, hold buffer empty.
  - IF/ID register: pc=0, instr=NOP_INSTR, pc_plus_four=0, valid=0.
  - imem_req=0 while reset=1.
  - Reset mid-request abandons the request; imem is reset by the same signal.
- States:
  - RUN: imem_req=1, imem_addr=pc.
  - DROP: imem_req=1, imem_addr=drop_addr; a stale request is still outstanding and its response will be discarded.
  - HOLD: imem_req=0; fetched instruction is parked in hold_instr with hold_pc.
- Protocol rules:
  - A request, once raised, stays high with a stable address until acked; no aborts.
  - imem_ack may be high in the same cycle req rises (zero-wait memory), which gives 1 instr/cycle.
- Priority per edge, outside reset:
  1. redirect
  2. stall
  3. normal
- redirect=1, any state:
  - pc <= {target[31:2],2'b00}.
  - IF/ID <= bubble (instr=NOP_INSTR, valid=0, pc/pc_plus_four=0).
  - Hold buffer is cleared.
  - RUN with ack=0: drop_addr <= old pc, go to DROP.
  - RUN with ack=1: response discarded, stay RUN.
  - HOLD: go to RUN.
  - DROP with ack=0: stay DROP; drop_addr is unchanged and pc takes the new target.
  - DROP with ack=1: go to RUN.
- RUN, no redirect:
  - ack=1, stall=0: IF/ID <= {pc, imem_rdata, pc+4, valid=1}; pc <= pc+4.
  - ack=1, stall=1: hold_instr <= imem_rdata, hold_pc <= pc; pc <= pc+4; IF/ID unchanged; go to HOLD.
  - ack=0, stall=0: IF/ID <= bubble.
  - ack=0, stall=1: IF/ID unchanged.
- HOLD, no redirect:
  - stall=1: everything unchanged.
  - stall=0: IF/ID <= {hold_pc, hold_instr, hold_pc+4, valid=1}; go to RUN.
- DROP, no redirect:
  - ack=1: discard response, go to RUN.
  - IF/ID <= bubble if stall=0, otherwise unchanged.
- Arithmetic and alignment:
  - pc+4 is 32-bit modulo; 32'hFFFF_FFFC wraps to 0.
  - The low two PC bits are always 0.
- Ordering: no instruction is ever delivered twice, skipped, or delivered from the pre-redirect path after a redirect.
- fetch_out_* change only on clock edges; they are registered outputs.

Test Plan:
- Reset, imem_ack tied 1, rdata=addr-derived → after reset deassert, IF/ID shows pc 0,4,8,C on consecutive cycles with valid=1 and pc_plus_four = pc+4.
- ack asserted every 3rd cycle → exactly 2 bubbles (instr=0x00000013, valid=0) between consecutive real instructions; imem_addr stable while waiting.
- Zero-wait memory, pcWrite=IF_ID_write_en=0 for 3 cycles while pc=0x10 acks → IF/ID holds its prior content, req=0 during HOLD; on release, IF/ID shows pc=0x10 then 0x14, with no loss or duplication.
- Memory latency 4; redirect to 0x200 one cycle after a request to 0x40 is raised → imem_addr stays 0x40 until ack, that response is discarded, next request is to 0x200, and the first valid IF/ID pc is 0x200.
- Redirect to 0x80 while stall=1 and state=HOLD → IF/ID bubble, hold discarded, next request to 0x80; a second redirect during DROP (to 0x100) makes 0x100 the first delivered pc.
- reset asserted mid-wait with pc=0x30 → the next cycle shows req=0 and outputs at reset values; after release, the first request is to RESET_VECTOR. Separately, the pc wrap at 0xFFFFFFFC gives next pc 0.
